// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// Define MEM_BUS_TIMEOUT_EN to enable the per-transaction stall timeout.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        bus_err
);

   typedef enum logic [1:0] {StIdle = 2'd0, StOwn0 = 2'd1, StOwn1 = 2'd2} state_e;

   state_e state;
   logic   last;
   logic   own0, own1, sel_valid, timeout_hit, done;

   assign own0      = (state == StOwn0);
   assign own1      = (state == StOwn1);
   assign sel_valid = (own0 & m0_valid) | (own1 & m1_valid);

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] stall_cnt;

   // Counter is zero on every entry to an owner state since grants always pass through idle.
   always_ff @(posedge clk) begin
      if (reset || state == StIdle) stall_cnt <= '0;
      else if (!s_ready)            stall_cnt <= stall_cnt + 1'b1;
   end

   assign timeout_hit = sel_valid & ~s_ready & (stall_cnt == LIMIT);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

   // Dropping valid while owning is an abort: back to idle without a ready.
   assign done = (own0 | own1) & (~sel_valid | s_ready | timeout_hit);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= StIdle;
         last  <= 1'b1;
      end else begin
         unique case (state)
            StIdle: begin
               if (m0_valid && (!m1_valid || last)) state <= StOwn0;
               else if (m1_valid)                   state <= StOwn1;
            end
            StOwn0, StOwn1: begin
               if (done) begin
                  state <= StIdle;
                  last  <= own1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   always_comb begin
      s_valid = sel_valid & ~timeout_hit;
      s_instr = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      if (own0) begin
         s_instr = m0_instr;
         s_addr  = m0_addr;
         s_wdata = m0_wdata;
         s_wstrb = m0_wstrb;
      end else if (own1) begin
         s_instr = m1_instr;
         s_addr  = m1_addr;
         s_wdata = m1_wdata;
         s_wstrb = m1_wstrb;
      end
   end

   // Ready/rdata are masked during reset so an interrupted transaction never completes.
   assign m0_ready = ~reset & own0 & m0_valid & (s_ready | timeout_hit);
   assign m1_ready = ~reset & own1 & m1_valid & (s_ready | timeout_hit);
   assign m0_rdata = (own0 & ~reset) ? (timeout_hit ? ERR_DATA : s_rdata) : '0;
   assign m1_rdata = (own1 & ~reset) ? (timeout_hit ? ERR_DATA : s_rdata) : '0;
   assign grant    = {own1, own0};
   assign bus_err  = timeout_hit & ~reset;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, corner sequences, random vs. model.
// Timeout checks are active when MEM_BUS_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 16).
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_valid = 0, m0_instr = 0, m0_ready;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m0_rdata;
   logic [3:0]  m0_wstrb = 0;
   logic        m1_valid = 0, m1_instr = 0, m1_ready;
   logic [31:0] m1_addr = 0, m1_wdata = 0, m1_rdata;
   logic [3:0]  m1_wstrb = 0;
   logic        s_valid, s_instr, s_ready = 0, bus_err;
   logic [31:0] s_addr, s_wdata, s_rdata = 0;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .bus_err(bus_err)
   );

   typedef struct {
      logic       rst, v0, v1, sr;
      logic [1:0] g;
      logic       r0, r1;
   } vec_t;

   vec_t tbl[25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic v0, input logic v1, input logic sr,
                       input logic [31:0] rd);
      @(posedge clk);
      #1;
      reset    = rst;
      m0_valid = v0;
      m1_valid = v1;
      s_ready  = sr;
      s_rdata  = rd;
      @(negedge clk);
   endtask

   // Expected slave-side fields follow whichever master the row says owns the bus.
   task automatic chk_row(input string tag, input vec_t v, input logic [31:0] rd);
      logic sv;
      sv = (v.g == 2'b01) ? v.v0 : (v.g == 2'b10) ? v.v1 : 1'b0;
      chk({tag, " grant"}, 32'(grant), 32'(v.g));
      chk({tag, " s_valid"}, 32'(s_valid), 32'(sv));
      chk({tag, " s_addr"}, s_addr, (v.g == 2'b01) ? 32'h100 :
                                    (v.g == 2'b10) ? 32'h8000_0000 : 32'h0);
      chk({tag, " s_wdata"}, s_wdata, (v.g == 2'b10) ? 32'hA5 : 32'h0);
      chk({tag, " s_wstrb"}, 32'(s_wstrb), (v.g == 2'b10) ? 32'h1 : 32'h0);
      chk({tag, " s_instr"}, 32'(s_instr), (v.g == 2'b01) ? 32'h1 : 32'h0);
      chk({tag, " m0_ready"}, 32'(m0_ready), 32'(v.r0));
      chk({tag, " m1_ready"}, 32'(m1_ready), 32'(v.r1));
      chk({tag, " m0_rdata"}, m0_rdata, (v.g == 2'b01) ? rd : 32'h0);
      chk({tag, " m1_rdata"}, m1_rdata, (v.g == 2'b10) ? rd : 32'h0);
      chk({tag, " bus_err"}, 32'(bus_err), 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      // rst v0 v1 sr grant r0 r1
      tbl[0]  = '{0, 1, 0, 0, 2'b00, 0, 0};  // single m0 read, 2 stall cycles
      tbl[1]  = '{0, 1, 0, 0, 2'b01, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 2'b01, 0, 0};
      tbl[3]  = '{0, 1, 0, 1, 2'b01, 1, 0};
      tbl[4]  = '{0, 0, 0, 0, 2'b00, 0, 0};
      tbl[5]  = '{1, 0, 0, 0, 2'b00, 0, 0};  // reset, then continuous tie
      tbl[6]  = '{0, 1, 1, 0, 2'b00, 0, 0};
      tbl[7]  = '{0, 1, 1, 1, 2'b01, 1, 0};
      tbl[8]  = '{0, 1, 1, 0, 2'b00, 0, 0};
      tbl[9]  = '{0, 1, 1, 1, 2'b10, 0, 1};
      tbl[10] = '{0, 1, 1, 0, 2'b00, 0, 0};
      tbl[11] = '{0, 1, 1, 1, 2'b01, 1, 0};
      tbl[12] = '{0, 1, 1, 0, 2'b00, 0, 0};
      tbl[13] = '{0, 1, 1, 1, 2'b10, 0, 1};
      tbl[14] = '{0, 0, 0, 0, 2'b00, 0, 0};
      tbl[15] = '{0, 1, 0, 0, 2'b00, 0, 0};  // m1 arrives during a 5-cycle m0 stall
      tbl[16] = '{0, 1, 1, 0, 2'b01, 0, 0};
      tbl[17] = '{0, 1, 1, 0, 2'b01, 0, 0};
      tbl[18] = '{0, 1, 1, 0, 2'b01, 0, 0};
      tbl[19] = '{0, 1, 1, 0, 2'b01, 0, 0};
      tbl[20] = '{0, 1, 1, 0, 2'b01, 0, 0};
      tbl[21] = '{0, 1, 1, 1, 2'b01, 1, 0};
      tbl[22] = '{0, 0, 1, 0, 2'b00, 0, 0};
      tbl[23] = '{0, 0, 1, 1, 2'b10, 0, 1};
      tbl[24] = '{0, 0, 0, 0, 2'b00, 0, 0};

      m0_instr = 1'b1; m0_addr = 32'h100;       m0_wdata = 32'h0;  m0_wstrb = 4'h0;
      m1_instr = 1'b0; m1_addr = 32'h8000_0000; m1_wdata = 32'hA5; m1_wstrb = 4'h1;

      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset grant", 32'(grant), 32'h0);
      chk("reset s_valid", 32'(s_valid), 32'h0);
      chk("reset s_addr", s_addr, 32'h0);
      chk("reset ready", 32'({m1_ready, m0_ready}), 32'h0);
      chk("reset bus_err", 32'(bus_err), 32'h0);

      for (int i = 0; i < 25; i++) begin
         rd = (i == 3) ? 32'h1234_5678 : 32'h1111_0000 + 32'(i);
         step(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].sr, rd);
         chk_row($sformatf("vec%0d", i), tbl[i], rd);
      end

      // Reset while m0 owns a stalled bus, then abort by m1 dropping valid early.
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("rst_mid grant", 32'(grant), 32'h1);
      step(1, 1, 0, 1, 32'h7777_7777);
      chk("rst_mid m0_ready", 32'(m0_ready), 32'h0);
      chk("rst_mid m1_ready", 32'(m1_ready), 32'h0);
      step(0, 1, 1, 0, 0);
      chk("post_rst s_valid", 32'(s_valid), 32'h0);
      chk("post_rst grant", 32'(grant), 32'h0);
      step(0, 1, 1, 1, 32'h2222_3333);
      chk("post_rst tie grant", 32'(grant), 32'h1);
      chk("post_rst m0_ready", 32'(m0_ready), 32'h1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("abort grant", 32'(grant), 32'h2);
      chk("abort m1_ready", 32'(m1_ready), 32'h0);
      step(0, 1, 1, 0, 0);
      chk("abort idle grant", 32'(grant), 32'h0);
      step(0, 1, 1, 1, 0);
      chk("abort tie grant", 32'(grant), 32'h1);
      step(0, 0, 0, 0, 0);

      // Long stall: timeout after 16 stalled cycles, or indefinite wait without it.
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < 16; k++) begin
         step(0, 1, 0, 0, 0);
         chk($sformatf("stall%0d grant", k), 32'(grant), 32'h1);
         chk($sformatf("stall%0d bus_err", k), 32'(bus_err), 32'h0);
         chk($sformatf("stall%0d m0_ready", k), 32'(m0_ready), 32'h0);
      end
`ifdef MEM_BUS_TIMEOUT_EN
      step(0, 1, 0, 0, 32'h5555_0000);
      chk("tmo m0_ready", 32'(m0_ready), 32'h1);
      chk("tmo m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk("tmo bus_err", 32'(bus_err), 32'h1);
      chk("tmo s_valid", 32'(s_valid), 32'h0);
      step(0, 0, 0, 0, 0);
      chk("tmo after grant", 32'(grant), 32'h0);
      chk("tmo after bus_err", 32'(bus_err), 32'h0);
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < 16; k++) step(0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 32'h0BAD_F00D);
      chk("limit ready m0_ready", 32'(m0_ready), 32'h1);
      chk("limit ready m0_rdata", m0_rdata, 32'h0BAD_F00D);
      chk("limit ready bus_err", 32'(bus_err), 32'h0);
      step(0, 0, 0, 0, 0);
`else
      step(0, 1, 0, 0, 0);
      chk("no_tmo grant", 32'(grant), 32'h1);
      chk("no_tmo bus_err", 32'(bus_err), 32'h0);
      chk("no_tmo m0_ready", 32'(m0_ready), 32'h0);
      step(0, 1, 0, 1, 32'h0BAD_F00D);
      chk("no_tmo done m0_ready", 32'(m0_ready), 32'h1);
      chk("no_tmo done m0_rdata", m0_rdata, 32'h0BAD_F00D);
      step(0, 0, 0, 0, 0);
`endif

      // Random traffic against a transaction-level model.
      step(1, 0, 0, 0, 0);
      begin
         int          owner, last_m, stall;
         bit          p0, p1, to;
         logic [31:0] a0, a1;
         owner = 0; last_m = 2; stall = 0; p0 = 0; p1 = 0; a0 = 0; a1 = 0;
         for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (!p0 && ($urandom % 2 == 0)) begin p0 = 1; a0 = $urandom; end
            if (!p1 && ($urandom % 2 == 0)) begin p1 = 1; a1 = $urandom; end
            reset    = 1'b0;
            m0_valid = p0; m0_addr = a0;
            m1_valid = p1; m1_addr = a1;
            s_ready  = ($urandom % 3 == 0);
            s_rdata  = $urandom;
            @(negedge clk);
            to = 0;
`ifdef MEM_BUS_TIMEOUT_EN
            to = (owner != 0) && (stall == 16) && !s_ready;
`endif
            chk("rnd grant", 32'(grant), (owner == 1) ? 32'h1 : (owner == 2) ? 32'h2 : 32'h0);
            chk("rnd s_valid", 32'(s_valid), 32'((owner != 0) && !to));
            chk("rnd s_addr", s_addr, (owner == 1) ? a0 : (owner == 2) ? a1 : 32'h0);
            chk("rnd m0_ready", 32'(m0_ready), 32'((owner == 1) && (s_ready || to)));
            chk("rnd m1_ready", 32'(m1_ready), 32'((owner == 2) && (s_ready || to)));
            chk("rnd m0_rdata", m0_rdata,
                (owner == 1) ? (to ? 32'hDEAD_BEEF : s_rdata) : 32'h0);
            chk("rnd m1_rdata", m1_rdata,
                (owner == 2) ? (to ? 32'hDEAD_BEEF : s_rdata) : 32'h0);
            chk("rnd bus_err", 32'(bus_err), 32'(to));
            if (owner != 0) begin
               if (s_ready || to) begin
                  last_m = owner;
                  if (owner == 1) p0 = 0; else p1 = 0;
                  owner = 0;
               end else begin
                  stall++;
               end
            end else if (p0 || p1) begin
               owner = (p0 && p1) ? 3 - last_m : (p0 ? 1 : 2);
               stall = 0;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
